// File: rtl/gpio_in_capture_pkg.sv
// Shared constants for the GPIO input capture block: default debounce sizing
// and the event counter width/limit, plus the saturating increment helper.
package gpio_in_capture_pkg;

    localparam int DB_W_DEF      = 16;
    localparam int DB_CYCLES_DEF = 50000;

    localparam int                   EVT_CNT_W   = 16;
    localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 16'hFFFF;

    function automatic logic [EVT_CNT_W-1:0] evt_sat_inc(input logic [EVT_CNT_W-1:0] v);
        return (v == EVT_CNT_MAX) ? v : v + EVT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: 2-flop synchroniser, stability counter, accepted level and
// single-cycle rise/fall pulses coincident with the level update.
module gpio_debounce
    import gpio_in_capture_pkg::*;
#(
    parameter int DB_W      = DB_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [DB_W-1:0] CNT_TERM = DB_W'(DB_CYCLES - 1);

    logic            s1_q;
    logic            s2_q;
    logic            stable_q;
    logic            stable_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;
    logic            update;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= pin_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        update   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_TERM) begin
            cnt_d = cnt_q + DB_W'(1);
        end else begin
            stable_d = s2_q;
            cnt_d    = '0;
            update   = 1'b1;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = update & s2_q;
    assign fall_o  = update & ~s2_q;

endmodule

// File: rtl/gpio_in_capture.sv
// Debounced GPIO input capture with sticky edge-pending flags and irq.
// Optional event counter (evt_cnt/evt_cnt_clr) built when GPIO_IN_EVT_CNT_EN is defined.
module gpio_in_capture
    import gpio_in_capture_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int DB_W      = DB_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN-1:0]      gpio_in,
    input  logic [N_IN-1:0]      rise_en,
    input  logic [N_IN-1:0]      fall_en,
    input  logic                 clr_valid,
    input  logic [N_IN-1:0]      clr_mask,
`ifdef GPIO_IN_EVT_CNT_EN
    input  logic                 evt_cnt_clr,
    output logic [EVT_CNT_W-1:0] evt_cnt,
`endif
    output logic [N_IN-1:0]      level,
    output logic [N_IN-1:0]      pending,
    output logic                 irq
);

    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
    logic [N_IN-1:0] set_vec;
    logic [N_IN-1:0] pending_q;
    logic [N_IN-1:0] pending_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        gpio_debounce #(
            .DB_W      (DB_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (gpio_in[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    // Set is OR-ed after the clear so a coincident edge is never lost.
    assign set_vec   = (rise & rise_en) | (fall & fall_en);
    assign pending_d = (pending_q & ~(clr_mask & {N_IN{clr_valid}})) | set_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
    assign irq     = |pending_q;

`ifdef GPIO_IN_EVT_CNT_EN
    logic [EVT_CNT_W-1:0] evt_cnt_q;
    logic [EVT_CNT_W-1:0] evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_cnt_clr) begin
            evt_cnt_d = '0;
        end else if (|set_vec) begin
            evt_cnt_d = evt_sat_inc(evt_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule
